// File: rtl/ws_seq_if.sv
// Go/done handshake, config and memory/PE-array strobe bundle for ws_seq_controller.
interface ws_seq_if #(
  parameter int unsigned ROWS   = 3,
  parameter int unsigned COLS   = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic                         go;
  logic [CNT_W-1:0]             cfg_num_vec;
  logic [CNT_W-1:0]             cfg_num_tiles;
  logic                         busy;
  logic                         done;
  logic                         cfg_err;
  logic                         load_weight;
  logic [ADDR_W-1:0]            weight_addr;
  logic [COLS-1:0][ADDR_W-1:0]  iact_addr;
  logic [COLS-1:0]              load_iact;
  logic [ROWS-1:0][ADDR_W-1:0]  psum_addr;
  logic [ROWS-1:0]              psum_valid;
  logic [CNT_W-1:0]             tile_idx;

  modport master (
    output go, cfg_num_vec, cfg_num_tiles,
    input  busy, done, cfg_err, load_weight, weight_addr, iact_addr,
           load_iact, psum_addr, psum_valid, tile_idx
  );

  modport slave (
    input  go, cfg_num_vec, cfg_num_tiles,
    output busy, done, cfg_err, load_weight, weight_addr, iact_addr,
           load_iact, psum_addr, psum_valid, tile_idx
  );
endinterface

// File: rtl/ws_seq_controller.sv
// Multi-tile weight-stationary PE array sequencer: weight load, skewed iact stream,
// skewed psum write strobes, realigned to memory read and PE pipeline latency.
module ws_seq_controller #(
  parameter int unsigned ROWS   = 3,
  parameter int unsigned COLS   = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned PE_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  ws_seq_if.slave  bus
);

  // Local cycle counter holds N plus the fixed skew/latency overhead.
  localparam int unsigned TW      = CNT_W + 8;
  localparam int unsigned LW_LAST = COLS + RD_LAT - 1;
  localparam int unsigned ST_OVH  = COLS + ROWS + PE_LAT + RD_LAT - 2;

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DONE} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  tile_q, tile_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  m_q, m_d;
  logic [ADDR_W-1:0] wbase_q, wbase_d;
  logic [ADDR_W-1:0] pbase_q, pbase_d;
  logic              err_q, err_d;
  logic [TW-1:0]     stream_len;

  logic                        busy_q, busy_c;
  logic                        done_q, done_c;
  logic                        lw_q, lw_c;
  logic [ADDR_W-1:0]           wa_q, wa_c;
  logic [COLS-1:0][ADDR_W-1:0] ia_q, ia_c;
  logic [COLS-1:0]             li_q, li_c;
  logic [ROWS-1:0][ADDR_W-1:0] pa_q, pa_c;
  logic [ROWS-1:0]             pv_q, pv_c;

  // Next-state and job bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tile_d     = tile_q;
    n_d        = n_q;
    m_d        = m_q;
    wbase_d    = wbase_q;
    pbase_d    = pbase_q;
    err_d      = err_q;
    stream_len = TW'(n_q) + TW'(ST_OVH);
    unique case (state_q)
      IDLE: begin
        if (bus.go) begin
          n_d     = bus.cfg_num_vec;
          m_d     = bus.cfg_num_tiles;
          tile_d  = '0;
          wbase_d = '0;
          pbase_d = '0;
          cnt_d   = '0;
          if (bus.cfg_num_vec == '0 || bus.cfg_num_tiles == '0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = LOAD_W;
          end
        end
      end
      LOAD_W: begin
        if (cnt_q == TW'(LW_LAST)) begin
          cnt_d   = '0;
          state_d = STREAM;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      STREAM: begin
        if (cnt_q == stream_len - TW'(1)) begin
          cnt_d = '0;
          if (tile_q < m_q - CNT_W'(1)) begin
            tile_d  = tile_q + CNT_W'(1);
            wbase_d = wbase_q + ADDR_W'(COLS);
            pbase_d = pbase_q + ADDR_W'(n_q);
            state_d = LOAD_W;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered copy lines up with it.
  always_comb begin
    busy_c = (state_d != IDLE);
    done_c = (state_d == DONE);
    lw_c   = 1'b0;
    wa_c   = '0;
    ia_c   = '0;
    li_c   = '0;
    pa_c   = '0;
    pv_c   = '0;
    if (state_d == LOAD_W) begin
      if (cnt_d < TW'(COLS)) wa_c = wbase_d + ADDR_W'(cnt_d);
      lw_c = (cnt_d >= TW'(RD_LAT));
    end
    if (state_d == STREAM) begin
      for (int c = 0; c < int'(COLS); c++) begin
        if (cnt_d >= TW'(c) && (cnt_d - TW'(c)) < TW'(n_d))
          ia_c[c] = ADDR_W'(cnt_d - TW'(c));
        if (cnt_d >= TW'(c + RD_LAT) && (cnt_d - TW'(c + RD_LAT)) < TW'(n_d))
          li_c[c] = 1'b1;
      end
      for (int r = 0; r < int'(ROWS); r++) begin
        if (cnt_d >= TW'(COLS - 1 + r + RD_LAT + PE_LAT) &&
            (cnt_d - TW'(COLS - 1 + r + RD_LAT + PE_LAT)) < TW'(n_d)) begin
          pv_c[r] = 1'b1;
          pa_c[r] = pbase_d + ADDR_W'(cnt_d - TW'(COLS - 1 + r + RD_LAT + PE_LAT));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tile_q  <= '0;
      n_q     <= '0;
      m_q     <= '0;
      wbase_q <= '0;
      pbase_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lw_q    <= 1'b0;
      wa_q    <= '0;
      ia_q    <= '0;
      li_q    <= '0;
      pa_q    <= '0;
      pv_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tile_q  <= tile_d;
      n_q     <= n_d;
      m_q     <= m_d;
      wbase_q <= wbase_d;
      pbase_q <= pbase_d;
      err_q   <= err_d;
      busy_q  <= busy_c;
      done_q  <= done_c;
      lw_q    <= lw_c;
      wa_q    <= wa_c;
      ia_q    <= ia_c;
      li_q    <= li_c;
      pa_q    <= pa_c;
      pv_q    <= pv_c;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.cfg_err     = err_q;
  assign bus.load_weight = lw_q;
  assign bus.weight_addr = wa_q;
  assign bus.iact_addr   = ia_q;
  assign bus.load_iact   = li_q;
  assign bus.psum_addr   = pa_q;
  assign bus.psum_valid  = pv_q;
  assign bus.tile_idx    = tile_q;

endmodule

// File: tb/tb_ws_seq_controller.sv
// Directed bench for ws_seq_controller: default 3x3 instance plus a 4x2 parameter sweep instance.
module tb_ws_seq_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ws_seq_if #(.ROWS(3), .COLS(3)) b0 ();
  ws_seq_if #(.ROWS(4), .COLS(2)) b1 ();

  ws_seq_controller #(.ROWS(3), .COLS(3), .RD_LAT(1), .PE_LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  ws_seq_controller #(.ROWS(4), .COLS(2), .RD_LAT(2), .PE_LAT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  int checks = 0;
  int passed = 0;

  logic        r_lw  [0:63];
  logic [31:0] r_wa  [0:63];
  logic [31:0] r_ia1 [0:63];
  logic [3:0]  r_li  [0:63];
  logic [3:0]  r_pv  [0:63];
  logic [31:0] r_pa  [0:63][0:3];
  logic        r_dn  [0:63];
  logic        r_busy[0:63];
  logic        r_err [0:63];
  logic [15:0] r_ti  [0:63];

  task automatic chk(input string tag, input int c, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, c, obs, exp);
  endtask

  task automatic sample(input int sel, input int c);
    if (sel == 0) begin
      r_lw[c] = b0.load_weight;   r_wa[c] = b0.weight_addr;  r_ia1[c] = b0.iact_addr[1];
      r_li[c] = {1'b0, b0.load_iact};  r_pv[c] = {1'b0, b0.psum_valid};
      for (int r = 0; r < 3; r++) r_pa[c][r] = b0.psum_addr[r];
      r_pa[c][3] = '0;
      r_dn[c] = b0.done;  r_busy[c] = b0.busy;  r_err[c] = b0.cfg_err;  r_ti[c] = b0.tile_idx;
    end else begin
      r_lw[c] = b1.load_weight;   r_wa[c] = b1.weight_addr;  r_ia1[c] = b1.iact_addr[1];
      r_li[c] = {2'b0, b1.load_iact};  r_pv[c] = b1.psum_valid;
      for (int r = 0; r < 4; r++) r_pa[c][r] = b1.psum_addr[r];
      r_dn[c] = b1.done;  r_busy[c] = b1.busy;  r_err[c] = b1.cfg_err;  r_ti[c] = b1.tile_idx;
    end
  endtask

  // Go is raised at a falling edge; that clock period is cycle 0.
  task automatic start(input int sel, input int n, input int m);
    @(negedge clk);
    if (sel == 0) begin
      b0.cfg_num_vec = 16'(n); b0.cfg_num_tiles = 16'(m); b0.go = 1'b1;
    end else begin
      b1.cfg_num_vec = 16'(n); b1.cfg_num_tiles = 16'(m); b1.go = 1'b1;
    end
    sample(sel, 0);
  endtask

  task automatic run(input int sel, input int ncyc, input int extra_go);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (sel == 0) b0.go = (c == extra_go);
      else          b1.go = (c == extra_go);
      sample(sel, c);
    end
  endtask

  task automatic check_single_tile(input string tag);
    for (int c = 0; c <= 17; c++) begin
      chk({tag, ".load_weight"}, c, 64'(r_lw[c]), 64'(c >= 2 && c <= 4));
      chk({tag, ".weight_addr"}, c, 64'(r_wa[c]), 64'((c >= 1 && c <= 3) ? c - 1 : 0));
      chk({tag, ".load_iact0"},  c, 64'(r_li[c][0]), 64'(c >= 6 && c <= 9));
      chk({tag, ".load_iact2"},  c, 64'(r_li[c][2]), 64'(c >= 8 && c <= 11));
      chk({tag, ".iact_addr1"},  c, 64'(r_ia1[c]), 64'((c >= 6 && c <= 9) ? c - 6 : 0));
      chk({tag, ".psum_valid0"}, c, 64'(r_pv[c][0]), 64'(c >= 9 && c <= 12));
      chk({tag, ".psum_addr0"},  c, 64'(r_pa[c][0]), 64'((c >= 9 && c <= 12) ? c - 9 : 0));
      chk({tag, ".psum_valid2"}, c, 64'(r_pv[c][2]), 64'(c >= 11 && c <= 14));
      chk({tag, ".psum_addr2"},  c, 64'(r_pa[c][2]), 64'((c >= 11 && c <= 14) ? c - 11 : 0));
      chk({tag, ".done"},        c, 64'(r_dn[c]), 64'(c == 15));
      chk({tag, ".busy"},        c, 64'(r_busy[c]), 64'(c >= 1 && c <= 15));
    end
  endtask

  initial begin
    b0.go = 1'b0; b0.cfg_num_vec = '0; b0.cfg_num_tiles = '0;
    b1.go = 1'b0; b1.cfg_num_vec = '0; b1.cfg_num_tiles = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.busy",  0, 64'(b0.busy), 64'(0));
    chk("rst.done",  0, 64'(b0.done), 64'(0));
    chk("rst.err",   0, 64'(b0.cfg_err), 64'(0));
    chk("rst.pv",    0, 64'(b0.psum_valid), 64'(0));
    chk("rst.wa",    0, 64'(b0.weight_addr), 64'(0));
    chk("rst.tile",  0, 64'(b0.tile_idx), 64'(0));
    chk("rst.busy1", 0, 64'(b1.busy), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single tile, N=4 M=1
    start(0, 4, 1);
    run(0, 17, -1);
    check_single_tile("one");

    // Two tiles, N=2 M=2
    start(0, 2, 2);
    run(0, 27, -1);
    for (int c = 1; c <= 3; c++) chk("two.wa_t0", c, 64'(r_wa[c]), 64'(c - 1));
    for (int c = 13; c <= 15; c++) chk("two.wa_t1", c, 64'(r_wa[c]), 64'(c - 10));
    chk("two.wa_gap", 16, 64'(r_wa[16]), 64'(0));
    for (int c = 1; c <= 24; c++) chk("two.tile", c, 64'(r_ti[c]), 64'((c >= 13) ? 1 : 0));
    chk("two.pv0_t0a", 9,  64'(r_pv[9][0]),  64'(1));
    chk("two.pa0_t0b", 10, 64'(r_pa[10][0]), 64'(1));
    chk("two.pv0_off", 11, 64'(r_pv[11][0]), 64'(0));
    chk("two.pv0_t1a", 21, 64'(r_pv[21][0]), 64'(1));
    chk("two.pa0_t1a", 21, 64'(r_pa[21][0]), 64'(2));
    chk("two.pa0_t1b", 22, 64'(r_pa[22][0]), 64'(3));
    chk("two.pa2_t1a", 23, 64'(r_pa[23][2]), 64'(2));
    chk("two.pa2_t1b", 24, 64'(r_pa[24][2]), 64'(3));
    chk("two.pv2_t1b", 24, 64'(r_pv[24][2]), 64'(1));
    for (int c = 0; c <= 27; c++) chk("two.done", c, 64'(r_dn[c]), 64'(c == 25));

    // Zero config, then a valid go clears cfg_err
    start(0, 0, 5);
    run(0, 4, -1);
    for (int c = 0; c <= 4; c++) begin
      chk("zero.done",  c, 64'(r_dn[c]), 64'(c == 1));
      chk("zero.err",   c, 64'(r_err[c]), 64'(c >= 1));
      chk("zero.busy",  c, 64'(r_busy[c]), 64'(c == 1));
      chk("zero.lw",    c, 64'(r_lw[c]), 64'(0));
      chk("zero.li",    c, 64'(r_li[c]), 64'(0));
      chk("zero.pv",    c, 64'(r_pv[c]), 64'(0));
    end
    start(0, 1, 1);
    run(0, 13, -1);
    chk("clr.err",  1,  64'(r_err[1]), 64'(0));
    chk("clr.done", 12, 64'(r_dn[12]), 64'(1));
    chk("clr.early", 11, 64'(r_dn[11]), 64'(0));

    // Go while busy (mid STREAM) and go in the DONE cycle are both ignored
    start(0, 4, 1);
    run(0, 17, 8);
    check_single_tile("gobusy");
    start(0, 4, 1);
    run(0, 20, 15);
    chk("godone.busy16", 16, 64'(r_busy[16]), 64'(0));
    chk("godone.busy17", 17, 64'(r_busy[17]), 64'(0));
    chk("godone.lw18",   18, 64'(r_lw[18]), 64'(0));
    chk("godone.done20", 20, 64'(r_dn[20]), 64'(0));

    // Reset during LOAD_W of tile 1 clears outputs without a clock edge
    start(0, 2, 2);
    run(0, 14, -1);
    chk("abort.pre_lw",   14, 64'(r_lw[14]), 64'(1));
    chk("abort.pre_wa",   14, 64'(r_wa[14]), 64'(4));
    chk("abort.pre_tile", 14, 64'(r_ti[14]), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("abort.busy", 14, 64'(b0.busy), 64'(0));
    chk("abort.lw",   14, 64'(b0.load_weight), 64'(0));
    chk("abort.wa",   14, 64'(b0.weight_addr), 64'(0));
    chk("abort.tile", 14, 64'(b0.tile_idx), 64'(0));
    chk("abort.done", 14, 64'(b0.done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort.idle_busy", 0, 64'(b0.busy), 64'(0));
    start(0, 4, 1);
    run(0, 17, -1);
    check_single_tile("after_abort");

    // Parameter sweep: ROWS=4 COLS=2 RD_LAT=2 PE_LAT=0, N=3 M=1 -> T=9
    start(1, 3, 1);
    run(1, 16, -1);
    for (int c = 0; c <= 16; c++) begin
      chk("sweep.wa",   c, 64'(r_wa[c]), 64'((c >= 1 && c <= 2) ? c - 1 : 0));
      chk("sweep.lw",   c, 64'(r_lw[c]), 64'(c >= 3 && c <= 4));
      chk("sweep.li1",  c, 64'(r_li[c][1]), 64'(c >= 8 && c <= 10));
      chk("sweep.pv0",  c, 64'(r_pv[c][0]), 64'(c >= 8 && c <= 10));
      chk("sweep.pv3",  c, 64'(r_pv[c][3]), 64'(c >= 11 && c <= 13));
      chk("sweep.pa3",  c, 64'(r_pa[c][3]), 64'((c >= 11 && c <= 13) ? c - 11 : 0));
      chk("sweep.done", c, 64'(r_dn[c]), 64'(c == 14));
      chk("sweep.busy", c, 64'(r_busy[c]), 64'(c >= 1 && c <= 14));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
